// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory stage.
// Holds the FSM state encoding, RISC-V funct3 width codes and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only know B/H/W (anything else is a word); loads also have BU/HU.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off,
                                           input logic       is_store);
        logic mis;
        if (is_store) begin
            case (funct3)
                F3_B:    mis = 1'b0;
                F3_H:    mis = off[0];
                default: mis = (off != 2'b00);
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: mis = 1'b0;
                F3_H, F3_HU: mis = off[0];
                default:     mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between the execute-side view and the 32-bit memory word:
// store replication plus write mask, and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: replicate the datum across lanes and select the lanes by offset.
    always_comb begin
        st_data = wdata;
        st_mask = 4'b1111;
        case (funct3)
            F3_B: begin
                st_data = {4{wdata[7:0]}};
                st_mask = 4'b0001 << off;
            end
            F3_H: begin
                st_data = {2{wdata[15:0]}};
                st_mask = 4'b0011 << off;
            end
            default: begin
                st_data = wdata;
                st_mask = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend according to funct3.
    always_comb begin
        byte_s  = rdata[{off, 3'b000} +: 8];
        half_s  = off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        case (funct3)
            F3_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ld_data = {24'd0, byte_s};
            F3_H:    ld_data = {{16{half_s[15]}}, half_s};
            F3_HU:   ld_data = {16'd0, half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage feeding physical memory: one request per handshake, a single
// word-aligned access after LAT cycles, and a registered result to write-back.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_misalign,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    lsu_state_e    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;

    logic [31:0] addr_r, wdata_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;
    logic        load_r, store_r;

    logic        in_ready_r, out_valid_r, out_misalign_r;
    logic [31:0] out_data_r;
    logic [4:0]  out_rd_r;
    logic        mem_valid_r, mem_wen_r;
    logic [31:0] mem_addr_r, mem_wdata_r;
    logic [3:0]  mem_wmask_r;

    logic        accept_s, mem_fire_s;
    logic        req_load_s, req_store_s;
    logic [31:0] req_addr_s, req_wdata_s;
    logic [2:0]  req_funct3_s;
    logic [4:0]  req_rd_s;
    logic [31:0] st_data_s, ld_data_s;
    logic [3:0]  st_mask_s;
    logic        res_take_s, res_mis_s;
    logic [31:0] res_data_s;

    assign accept_s = in_valid && (state_r == IDLE);

    // While idle the request comes straight from execute so LAT=1 can fire on the accept edge.
    always_comb begin
        if (state_r == IDLE) begin
            req_addr_s   = in_addr;
            req_wdata_s  = in_wdata;
            req_funct3_s = in_funct3;
            req_rd_s     = in_rd;
            req_store_s  = in_is_store;
            req_load_s   = in_is_load & ~in_is_store;
        end else begin
            req_addr_s   = addr_r;
            req_wdata_s  = wdata_r;
            req_funct3_s = funct3_r;
            req_rd_s     = rd_r;
            req_store_s  = store_r;
            req_load_s   = load_r;
        end
    end

    lsu_align u_align (
        .off     (req_addr_s[1:0]),
        .funct3  (req_funct3_s),
        .wdata   (req_wdata_s),
        .rdata   (mem_rdata),
        .st_data (st_data_s),
        .st_mask (st_mask_s),
        .ld_data (ld_data_s)
    );

    // Next-state, latency counter and result selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        res_take_s = 1'b0;
        res_mis_s  = 1'b0;
        res_data_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!req_load_s && !req_store_s) begin
                        state_s    = RESP;
                        res_take_s = 1'b1;
                        res_data_s = in_addr;
                    end else if (is_misaligned(req_funct3_s, req_addr_s[1:0], req_store_s)) begin
                        state_s    = RESP;
                        res_take_s = 1'b1;
                        res_mis_s  = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_INIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    state_s    = RESP;
                    res_take_s = 1'b1;
                    res_data_s = store_r ? 32'd0 : ld_data_s;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // The access cycle is the one whose registered state is WAIT with the counter expired.
    assign mem_fire_s = (state_s == WAIT) && (cnt_s == CNT_ZERO);

    // State, request latch and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            addr_r         <= 32'd0;
            wdata_r        <= 32'd0;
            funct3_r       <= 3'd0;
            rd_r           <= 5'd0;
            load_r         <= 1'b0;
            store_r        <= 1'b0;
            in_ready_r     <= 1'b1;
            out_valid_r    <= 1'b0;
            out_data_r     <= 32'd0;
            out_rd_r       <= 5'd0;
            out_misalign_r <= 1'b0;
            mem_valid_r    <= 1'b0;
            mem_wen_r      <= 1'b0;
            mem_addr_r     <= 32'd0;
            mem_wdata_r    <= 32'd0;
            mem_wmask_r    <= 4'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            if (accept_s) begin
                addr_r   <= in_addr;
                wdata_r  <= in_wdata;
                funct3_r <= in_funct3;
                rd_r     <= in_rd;
                load_r   <= req_load_s;
                store_r  <= req_store_s;
            end
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == RESP);
            if (res_take_s) begin
                out_data_r     <= res_data_s;
                out_rd_r       <= req_rd_s;
                out_misalign_r <= res_mis_s;
            end else if (state_s != RESP) begin
                out_data_r     <= 32'd0;
                out_rd_r       <= 5'd0;
                out_misalign_r <= 1'b0;
            end else begin
                out_data_r     <= out_data_r;
                out_rd_r       <= out_rd_r;
                out_misalign_r <= out_misalign_r;
            end
            mem_valid_r <= mem_fire_s;
            mem_wen_r   <= mem_fire_s && req_store_s;
            mem_addr_r  <= mem_fire_s ? {req_addr_s[31:2], 2'b00} : 32'd0;
            mem_wdata_r <= (mem_fire_s && req_store_s) ? st_data_s : 32'd0;
            mem_wmask_r <= (mem_fire_s && req_store_s) ? st_mask_s : 4'd0;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_rd       = out_rd_r;
    assign out_misalign = out_misalign_r;
    assign mem_valid    = mem_valid_r;
    assign mem_wen      = mem_wen_r;
    assign mem_raddr    = mem_addr_r;
    assign mem_waddr    = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_wmask    = {4'b0000, mem_wmask_r};

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: three instances (LAT 1, 3, 4) share one stimulus stream and
// are compared every cycle against a transaction-level model, plus literal spot checks.
module tb_lsu_mem_stage;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_is_load = 1'b0;
    logic        in_is_store = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic        out_ready = 1'b1;
    logic [31:0] mem_rdata = 32'd0;

    logic        in_ready [N];
    logic        out_valid [N];
    logic [31:0] out_data [N];
    logic [4:0]  out_rd [N];
    logic        out_misalign [N];
    logic        mem_valid [N];
    logic [31:0] mem_raddr [N];
    logic        mem_wen [N];
    logic [31:0] mem_waddr [N];
    logic [31:0] mem_wdata [N];
    logic [7:0]  mem_wmask [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        lsu_mem_stage #(.LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready[g]),
            .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
            .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_data(out_data[g]), .out_rd(out_rd[g]), .out_misalign(out_misalign[g]),
            .mem_valid(mem_valid[g]), .mem_raddr(mem_raddr[g]), .mem_rdata(mem_rdata),
            .mem_wen(mem_wen[g]), .mem_waddr(mem_waddr[g]),
            .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    // Access width in bytes; stores only recognise byte and halfword codes.
    function automatic int nbytes(input logic [2:0] f3, input logic st);
        if (f3 == 3'b000 || (!st && f3 == 3'b100)) return 1;
        if (f3 == 3'b001 || (!st && f3 == 3'b101)) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n;
        int off;
        longint raw;
        longint rdl;
        n   = nbytes(f3, 1'b0);
        off = int'(a % 32'd4);
        rdl = longint'({32'd0, rd});
        if (n == 4) return rd;
        raw = (rdl >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if ((f3 == 3'b000 || f3 == 3'b001) && raw >= (longint'(1) << (8 * n - 1)))
            raw = raw - (longint'(1) << (8 * n));
        return raw[31:0];
    endfunction

    function automatic logic [7:0] st_mask(input logic [2:0] f3, input logic [31:0] a);
        int n;
        int m;
        logic [7:0] r;
        n = nbytes(f3, 1'b1);
        m = ((1 << n) - 1) << int'(a % 32'd4);
        r = 8'(m);
        return {4'b0000, r[3:0]};
    endfunction

    function automatic logic [31:0] st_word(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = nbytes(f3, 1'b1);
        if (n == 1) return {24'd0, wd[7:0]} * 32'h01010101;
        if (n == 2) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    // Transaction model: pending access (with age since accept) or pending result.
    logic        m_pend [N];
    logic        m_resp [N];
    int          m_age [N];
    logic        m_st [N];
    logic        m_mis [N];
    logic [2:0]  m_f3 [N];
    logic [4:0]  m_rd [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_wd [N];
    logic [31:0] m_data [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_pend[i] <= 1'b0;
                m_resp[i] <= 1'b0;
            end else if (!m_pend[i] && !m_resp[i]) begin
                if (in_valid) begin
                    m_st[i]   <= in_is_store;
                    m_f3[i]   <= in_funct3;
                    m_rd[i]   <= in_rd;
                    m_addr[i] <= in_addr;
                    m_wd[i]   <= in_wdata;
                    m_mis[i]  <= 1'b0;
                    if (!in_is_load && !in_is_store) begin
                        m_resp[i] <= 1'b1;
                        m_data[i] <= in_addr;
                    end else if ((in_addr % nbytes(in_funct3, in_is_store)) != 0) begin
                        m_resp[i] <= 1'b1;
                        m_data[i] <= 32'd0;
                        m_mis[i]  <= 1'b1;
                    end else begin
                        m_pend[i] <= 1'b1;
                        m_age[i]  <= 1;
                    end
                end
            end else if (m_pend[i]) begin
                if (m_age[i] == lat_of(i)) begin
                    m_pend[i] <= 1'b0;
                    m_resp[i] <= 1'b1;
                    m_data[i] <= m_st[i] ? 32'd0 : load_val(m_f3[i], m_addr[i], mem_rdata);
                end else begin
                    m_age[i] <= m_age[i] + 1;
                end
            end else if (out_ready) begin
                m_resp[i] <= 1'b0;
            end
        end
    end

    logic        chk_en = 1'b0;
    int          mvcnt [N];
    logic [31:0] cap_waddr, cap_wdata;
    logic [7:0]  cap_wmask;
    logic        cap_wen;
    logic [31:0] last_data [N];
    logic [4:0]  last_rd [N];
    logic        last_mis [N];

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic ev;
                ev = m_pend[i] && (m_age[i] == lat_of(i));
                chk("in_ready", i, 32'(in_ready[i]), 32'(!m_pend[i] && !m_resp[i]));
                chk("out_valid", i, 32'(out_valid[i]), 32'(m_resp[i]));
                chk("mem_valid", i, 32'(mem_valid[i]), 32'(ev));
                chk("mem_wen", i, 32'(mem_wen[i]), 32'(ev && m_st[i]));
                chk("mem_wmask", i, 32'(mem_wmask[i]), (ev && m_st[i]) ? 32'(st_mask(m_f3[i], m_addr[i])) : 32'd0);
                if (ev) begin
                    chk("mem_raddr", i, mem_raddr[i], m_addr[i] & 32'hFFFF_FFFC);
                    chk("mem_waddr", i, mem_waddr[i], m_addr[i] & 32'hFFFF_FFFC);
                    if (m_st[i]) chk("mem_wdata", i, mem_wdata[i], st_word(m_f3[i], m_wd[i]));
                end
                if (m_resp[i]) begin
                    chk("out_data", i, out_data[i], m_data[i]);
                    chk("out_rd", i, 32'(out_rd[i]), 32'(m_rd[i]));
                    chk("out_misalign", i, 32'(out_misalign[i]), 32'(m_mis[i]));
                end
                if (mem_valid[i]) mvcnt[i] = mvcnt[i] + 1;
                if (out_valid[i] && out_ready) begin
                    last_data[i] = out_data[i];
                    last_rd[i]   = out_rd[i];
                    last_mis[i]  = out_misalign[i];
                end
            end
            if (mem_valid[0]) begin
                cap_wen   = mem_wen[0];
                cap_waddr = mem_waddr[0];
                cap_wdata = mem_wdata[0];
                cap_wmask = mem_wmask[0];
            end
        end
    end

    function automatic logic all_ready();
        return in_ready[0] && in_ready[1] && in_ready[2];
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd, input logic [31:0] rdata);
        int t;
        t = 0;
        @(negedge clk);
        while (!all_ready() && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 32'd0, 32'd1);
        for (int i = 0; i < N; i++) mvcnt[i] = 0;
        cap_wen = 1'b0; cap_waddr = 32'd0; cap_wdata = 32'd0; cap_wmask = 8'd0;
        in_addr = a; in_wdata = wd; in_funct3 = f3; in_is_load = ld; in_is_store = st;
        in_rd = rd; mem_rdata = rdata; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic settle();
        int t;
        t = 0;
        @(negedge clk);
        while (!all_ready() && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) chk("drain_timeout", 0, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
            chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
            chk("rst_mem_valid", i, 32'(mem_valid[i]), 32'd0);
            chk("rst_mem_wen", i, 32'(mem_wen[i]), 32'd0);
            chk("rst_mem_wmask", i, 32'(mem_wmask[i]), 32'd0);
            chk("rst_out_data", i, out_data[i], 32'd0);
        end
        rst = 1'b0;
        chk_en = 1'b1;

        issue(32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b1, 5'd1, 32'd0);
        settle();
        for (int i = 0; i < N; i++) chk("sw_one_access", i, 32'(mvcnt[i]), 32'd1);
        chk("sw_wen", 0, 32'(cap_wen), 32'd1);
        chk("sw_waddr", 0, cap_waddr, 32'h8000_0004);
        chk("sw_wmask", 0, 32'(cap_wmask), 32'h0000_000F);
        chk("sw_wdata", 0, cap_wdata, 32'hDEAD_BEEF);
        chk("sw_out_data", 0, last_data[0], 32'd0);

        issue(32'h8000_0003, 32'd0, 3'b000, 1'b1, 1'b0, 5'd2, 32'h80FF_1234);
        settle();
        chk("lb_data", 0, last_data[0], 32'hFFFF_FF80);
        chk("lb_rd", 2, 32'(last_rd[2]), 32'd2);
        issue(32'h8000_0003, 32'd0, 3'b100, 1'b1, 1'b0, 5'd2, 32'h80FF_1234);
        settle();
        chk("lbu_data", 1, last_data[1], 32'h0000_0080);

        issue(32'h8000_0002, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 5'd4, 32'd0);
        settle();
        chk("sh_wmask", 0, 32'(cap_wmask), 32'h0000_000C);
        chk("sh_wdata", 0, cap_wdata, 32'hABCD_ABCD);

        issue(32'h8000_0001, 32'd0, 3'b001, 1'b1, 1'b0, 5'd5, 32'h80FF_1234);
        settle();
        for (int i = 0; i < N; i++) chk("lh_mis_no_access", i, 32'(mvcnt[i]), 32'd0);
        chk("lh_misalign", 0, 32'(last_mis[0]), 32'd1);
        chk("lh_mis_data", 0, last_data[0], 32'd0);

        issue(32'h8000_0002, 32'd0, 3'b101, 1'b1, 1'b0, 5'd6, 32'h80FF_1234);
        settle();
        chk("lhu_data", 2, last_data[2], 32'h0000_80FF);
        issue(32'h8000_0002, 32'd0, 3'b001, 1'b1, 1'b0, 5'd6, 32'h80FF_1234);
        settle();
        chk("lh_data", 0, last_data[0], 32'hFFFF_80FF);

        issue(32'hFFFF_FFFD, 32'h0000_005A, 3'b000, 1'b1, 1'b1, 5'd8, 32'd0);
        settle();
        chk("sb_top_waddr", 0, cap_waddr, 32'hFFFF_FFFC);
        chk("sb_top_wmask", 0, 32'(cap_wmask), 32'h0000_0002);
        chk("sb_top_wdata", 0, cap_wdata, 32'h5A5A_5A5A);

        issue(32'h8000_0001, 32'h1234_5678, 3'b100, 1'b0, 1'b1, 5'd9, 32'd0);
        settle();
        chk("st_f3other_misalign", 1, 32'(last_mis[1]), 32'd1);

        issue(32'h1234_5678, 32'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'd0);
        settle();
        chk("nonmem_data", 0, last_data[0], 32'h1234_5678);
        chk("nonmem_rd", 0, 32'(last_rd[0]), 32'd7);
        for (int i = 0; i < N; i++) chk("nonmem_no_access", i, 32'(mvcnt[i]), 32'd0);

        out_ready = 1'b0;
        issue(32'h8000_0010, 32'd0, 3'b010, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_valid[2]) break;
        end
        chk("lat4_access_cycle", 2, 32'(n), 32'd4);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold_out_valid", 2, 32'(out_valid[2]), 32'd1);
            chk("hold_out_data", 2, out_data[2], 32'hCAFE_F00D);
            chk("hold_in_ready", 2, 32'(in_ready[2]), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        settle();

        issue(32'h8000_0008, 32'h1122_3344, 3'b010, 1'b0, 1'b1, 5'd3, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_in_ready", 1, 32'(in_ready[1]), 32'd1);
        chk("rst_wait_out_valid", 1, 32'(out_valid[1]), 32'd0);
        repeat (6) @(negedge clk);
        chk("rst_wait_no_access", 1, 32'(mvcnt[1]), 32'd0);
        chk("rst_wait_no_access", 2, 32'(mvcnt[2]), 32'd0);

        issue(32'h8000_0020, 32'd0, 3'b010, 1'b1, 1'b0, 5'd10, 32'h0102_0304);
        settle();
        chk("post_rst_lw", 1, last_data[1], 32'h0102_0304);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage directly upstream of the physical-memory block.
- Accepts one memory request per handshake from the execute stage.
- Converts the request into a single-cycle, word-aligned memory access with a byte-lane mask.
- Registers and extracts/extends the returned read data, then hands a result to write-back via valid/ready.
- A configurable wait counter emulates memory latency.

Parameters:
- LAT, 1, number of cycles from request acceptance to the memory access cycle (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid from execute
- in_ready  out  1  stage can accept a request
- in_addr  in  32  byte address (or ALU result for non-memory ops)
- in_wdata  in  32  store data (rs2)
- in_funct3  in  3  RISC-V width/sign code
- in_is_load  in  1  request is a load
- in_is_store  in  1  request is a store
- in_rd  in  5  destination register index
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts result
- out_data  out  32  load result, or in_addr for non-memory ops, 0 for stores
- out_rd  out  5  latched rd
- out_misalign  out  1  request was misaligned; no memory access made
- mem_valid  out  1  memory access strobe, exactly one cycle per access
- mem_raddr  out  32  word-aligned read address
- mem_rdata  in  32  read data, combinational in the mem_valid cycle
- mem_wen  out  1  write enable, only while mem_valid=1
- mem_waddr  out  32  word-aligned write address
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  8  byte-lane mask; bits[3:0] used, bits[7:4] always 0

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: state=IDLE. All outputs 0 except in_ready=1. A reset mid-WAIT drops the request with no memory access. A reset in RESP drops the result.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch addr, wdata, funct3, rd, load and store flags.
  - If in_is_store=1, it is a store regardless of in_is_load.
  - Non-memory op (both flags 0): go to RESP, out_data=in_addr.
  - Misaligned request: go to RESP, out_misalign=1, out_data=0, no memory access.
    - Halfword is misaligned when addr[0]=1.
    - Word is misaligned when addr[1:0]≠0.
  - Otherwise go to WAIT with cnt=LAT-1.
- WAIT:
  - in_ready=0.
  - If cnt≠0: cnt decrements, mem_valid=0.
  - If cnt==0: mem_valid=1 for this cycle only, then go to RESP.
    - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
    - mem_wen = store.
    - For a load, mem_rdata is captured and the lane is extracted at this clock edge.
- Addresses with addr[31:2] all ones are accessed normally; there is no wrap special case.
- Store lanes (off = addr[1:0]):
  - SB (000): wmask = 0001<<off, wdata = {4{wdata[7:0]}}.
  - SH (001): wmask = 0011<<off, wdata = {2{wdata[15:0]}}.
  - SW (010): wmask = 1111, wdata = wdata.
  - Other funct3 values on a store are treated as SW.
- Load extract (off = addr[1:0]):
  - Byte = mem_rdata[off*8+:8]; halfword = mem_rdata[off*8+:16].
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) or any other code returns the full word.
- RESP:
  - out_valid=1; out_data, out_rd and out_misalign are held stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE and drop out_valid.
  - The next request can be accepted one cycle later; there is no same-cycle bypass.
  - Stores return out_data=0.
- Outside the mem_valid cycle, mem_wen=0 and mem_wmask=0. The address and data outputs are don't-care but driven to 0.
- Throughput: at most one request per LAT+2 cycles.

Decomposition:
- lsu_pkg contains:
  - state enum {IDLE, WAIT, RESP}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - a misalignment check function.
- lsu_align is one combinational sub-module: store-lane shift and mask generation, plus load lane extract and extend.
- The FSM, counter and registers stay in lsu_mem_stage.

Test Plan:
- LAT=1, SW addr=0x80000004 wdata=0xDEADBEEF -> one mem_valid cycle with mem_wen=1, waddr=0x80000004, wmask=0x0F, wdata=0xDEADBEEF; then out_valid with out_data=0.
- LB addr=0x80000003, mem_rdata=0x80FF1234 -> out_data=0xFFFFFF80. Repeat as LBU -> out_data=0x00000080.
- SH addr=0x80000002 wdata=0x0000ABCD -> wmask=0x0C, wdata=0xABCDABCD. LH addr=0x80000001 -> out_misalign=1, mem_valid never asserted.
- LAT=4, LW -> mem_valid first high exactly 4 cycles after the acceptance edge. Hold out_ready=0 for 5 cycles -> out_data stable and in_ready=0 throughout.
- Non-memory op addr=0x12345678 rd=7 -> out_data=0x12345678, out_rd=7, and no mem_valid.
- Assert rst during WAIT with LAT=3 on a store -> no mem_valid/mem_wen pulse. The next cycle in_ready=1 and out_valid=0.
